mem_burst_arbiter: RTL
======================

Name: mem_burst_arbiter

Overview:
- Shares the single burst interface of the DDR3 burst engine between two client ports. Each client port has its own read and write burst channels.
- Round-robin arbitration over four sources. Exactly one burst is outstanding at a time.
- Sits between the video/test clients and the burst engine, in the phy_clk domain (mem_clk here).

Parameters:
- MEM_DATA_BITS, 64, burst data width.
- ADDR_BITS, 24, burst word address width.
- LEN_BITS, 10, burst length width.

Ports:
- mem_clk  in  1  sole clock; drive from DDR phy_clk.
- rst  in  1  synchronous, active-high reset.
- calib_done  in  1  DDR calibration complete; no grant while low.
- pN_rd_burst_req  in  1  per port N in {0,1}; read request, held until pN_rd_burst_finish.
- pN_rd_burst_len  in  LEN_BITS  words to read.
- pN_rd_burst_addr  in  ADDR_BITS  start address.
- pN_rd_burst_data_valid  out  1  read data valid for port N.
- pN_rd_burst_data  out  MEM_DATA_BITS  read data (broadcast).
- pN_rd_burst_finish  out  1  one-cycle read completion pulse.
- pN_wr_burst_req  in  1  write request, held until pN_wr_burst_finish.
- pN_wr_burst_len  in  LEN_BITS  words to write.
- pN_wr_burst_addr  in  ADDR_BITS  start address.
- pN_wr_burst_data_req  out  1  write data request to port N.
- pN_wr_burst_data  in  MEM_DATA_BITS  write data.
- pN_wr_burst_finish  out  1  one-cycle write completion pulse.
- m_rd_burst_req, m_rd_burst_len, m_rd_burst_addr  out  1/LEN_BITS/ADDR_BITS  to burst engine.
- m_rd_burst_data_valid, m_rd_burst_data, m_rd_burst_finish  in  1/MEM_DATA_BITS/1  from burst engine.
- m_wr_burst_req, m_wr_burst_len, m_wr_burst_addr  out  1/LEN_BITS/ADDR_BITS  to burst engine.
- m_wr_burst_data_req, m_wr_burst_finish  in  1/1  from burst engine.
- m_wr_burst_data  out  MEM_DATA_BITS  write data to burst engine.
- busy  out  1  burst in progress.
- grant_id  out  2  current or last granted source.

Behaviour:
- Source index: 0 = p0_wr, 1 = p0_rd, 2 = p1_wr, 3 = p1_rd.
- Reset values:
  - All outputs 0: req, len, addr, valid, finish, data_req, busy.
  - grant_id = 3; state IDLE; last-grant pointer = 3, so source 0 has first priority.
- State machine IDLE -> ARB -> RUN -> DONE -> IDLE.
- IDLE: go to ARB when calib_done=1 and any request is high.
- ARB, one cycle:
  - Pick the first requesting source searching from pointer+1 mod 4.
  - Register len/addr into m_*_len/addr.
  - Set grant_id and busy=1; update the pointer.
  - If len==0: skip RUN, go straight to DONE (no downstream request).
- RUN:
  - Assert the matching m_rd_burst_req or m_wr_burst_req; hold until the matching m_*_finish.
  - On finish: deassert req in the next cycle and go to DONE.
  - m_*_finish of the non-granted type is ignored.
- DONE, one cycle:
  - Pulse pN_*_finish for the granted source only; busy=0; back to IDLE.
  - This guarantees one idle cycle between bursts, so a requester's held req cannot be re-granted before it drops.
- Data path:
  - pN_rd_burst_data = m_rd_burst_data for all ports, combinational.
  - pN_rd_burst_data_valid = m_rd_burst_data_valid AND (grant is port N read AND state RUN).
  - pN_wr_burst_data_req = m_wr_burst_data_req gated the same way.
  - m_wr_burst_data = mux of granted port's data, combinational, select stable for the whole burst.
- Request latched at ARB. Addr/len changes during RUN are ignored.
- calib_done falling during RUN: the burst completes; no new grants until it rises again.
- Requests arriving during RUN/DONE wait; at most one grant per ARB cycle.
- Synchronous rst mid-burst: immediate return to reset values. Downstream req drops. No finish pulse.

Optional Feature:
- Macro ARB_WR_PRIORITY_EN.
- Defined: in ARB, any pending write (sources 0, 2) beats every read. Round-robin still applies within the write class and within the read class, each class using the shared pointer.
- Undefined: pure 4-way round-robin as above.

Decomposition:
- Package mem_arb_pkg:
  - Source index constants SRC_P0_WR..SRC_P1_RD.
  - State encoding localparams.
  - NUM_SRC=4.
- Sub-module rr_pick4: combinational 4-request round-robin picker. Inputs: req[3:0], ptr[1:0], class mask. Outputs: gnt_valid, gnt_idx.

Test Plan:
- Calibration gate: calib_done=0, p0 wr req len 16 -> no m_wr_burst_req. calib_done=1 -> m_wr_burst_req 2 cycles later; addr and len 16 forwarded.
- Fairness: all four sources request len 4 continuously after reset -> grant order 0,1,2,3,0. Exactly one finish pulse per burst, routed to the right port.
- Read data routing: p1 rd burst len 8 -> p1_rd_burst_data_valid high 8 cycles. p0_rd_burst_data_valid stays 0.
- Zero length: p0 rd len 0 -> p0_rd_burst_finish 2 cycles after the ARB cycle; m_rd_burst_req never asserted.
- Reset mid-burst: rst=1 during RUN of a len 64 write -> next cycle all outputs 0, grant_id=3; after release the next grant goes to source 0.
- ARB_WR_PRIORITY_EN: p0 rd and p1 wr requesting simultaneously -> p1 wr granted first with macro defined, p0 rd granted first without.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the burst arbiter: source indices, FSM encoding, class masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  localparam int NUM_SRC = 4;

  // Source index: bit 1 selects the client port, bit 0 selects read (1) / write (0).
  localparam logic [1:0] SRC_P0_WR = 2'd0;
  localparam logic [1:0] SRC_P0_RD = 2'd1;
  localparam logic [1:0] SRC_P1_WR = 2'd2;
  localparam logic [1:0] SRC_P1_RD = 2'd3;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ARB_ENC  = 2'd1;
  localparam logic [1:0] ST_RUN_ENC  = 2'd2;
  localparam logic [1:0] ST_DONE_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ARB  = ST_ARB_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } arb_state_t;

  // Request-class masks over the four sources.
  localparam logic [3:0] MASK_ALL = 4'b1111;
  localparam logic [3:0] MASK_WR  = 4'b0101;
  localparam logic [3:0] MASK_RD  = 4'b1010;

  function automatic logic src_is_rd(input logic [1:0] src);
    return src[0];
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker restricted to a class mask.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when to consume the pick.
module rr_pick4
  import mem_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] class_mask,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  logic [3:0] masked;
  logic [1:0] idx;

  // Search ptr+1, ptr+2, ptr+3, ptr; walking backwards lets the nearest hit win.
  always_comb begin
    masked    = req & class_mask;
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (masked[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one DDR burst engine between two client ports (rd+wr each), round-robin over 4 sources.
// Latency: request -> downstream req 2 cycles (IDLE, ARB); finish pulse 2 cycles after engine finish.
// Backpressure: one burst outstanding; other requests stay held until granted. Build option: ARB_WR_PRIORITY_EN.
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 24,
  parameter int LEN_BITS      = 10
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     calib_done,

  input  logic                     p0_rd_burst_req,
  input  logic [LEN_BITS-1:0]      p0_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     p0_rd_burst_addr,
  output logic                     p0_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] p0_rd_burst_data,
  output logic                     p0_rd_burst_finish,
  input  logic                     p0_wr_burst_req,
  input  logic [LEN_BITS-1:0]      p0_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     p0_wr_burst_addr,
  output logic                     p0_wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] p0_wr_burst_data,
  output logic                     p0_wr_burst_finish,

  input  logic                     p1_rd_burst_req,
  input  logic [LEN_BITS-1:0]      p1_rd_burst_len,
  input  logic [ADDR_BITS-1:0]     p1_rd_burst_addr,
  output logic                     p1_rd_burst_data_valid,
  output logic [MEM_DATA_BITS-1:0] p1_rd_burst_data,
  output logic                     p1_rd_burst_finish,
  input  logic                     p1_wr_burst_req,
  input  logic [LEN_BITS-1:0]      p1_wr_burst_len,
  input  logic [ADDR_BITS-1:0]     p1_wr_burst_addr,
  output logic                     p1_wr_burst_data_req,
  input  logic [MEM_DATA_BITS-1:0] p1_wr_burst_data,
  output logic                     p1_wr_burst_finish,

  output logic                     m_rd_burst_req,
  output logic [LEN_BITS-1:0]      m_rd_burst_len,
  output logic [ADDR_BITS-1:0]     m_rd_burst_addr,
  input  logic                     m_rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] m_rd_burst_data,
  input  logic                     m_rd_burst_finish,
  output logic                     m_wr_burst_req,
  output logic [LEN_BITS-1:0]      m_wr_burst_len,
  output logic [ADDR_BITS-1:0]     m_wr_burst_addr,
  input  logic                     m_wr_burst_data_req,
  input  logic                     m_wr_burst_finish,
  output logic [MEM_DATA_BITS-1:0] m_wr_burst_data,

  output logic                     busy,
  output logic [1:0]               grant_id
);

  arb_state_t state, state_nxt;

  logic [3:0]           req_vec;
  logic                 pick_valid;
  logic [1:0]           pick_idx;
  logic                 arb_valid;
  logic [LEN_BITS-1:0]  sel_len;
  logic [ADDR_BITS-1:0] sel_addr;
  logic                 granted_finish;
  logic                 in_run;
  logic [3:0]           fin_q;

  assign req_vec = {p1_rd_burst_req, p1_wr_burst_req, p0_rd_burst_req, p0_wr_burst_req};

  // grant_id doubles as the round-robin pointer: it always holds the last granted source.
`ifdef ARB_WR_PRIORITY_EN
  logic       wr_valid, rd_valid;
  logic [1:0] wr_idx, rd_idx;

  rr_pick4 u_pick_wr (
    .req        (req_vec),
    .ptr        (grant_id),
    .class_mask (MASK_WR),
    .gnt_valid  (wr_valid),
    .gnt_idx    (wr_idx)
  );

  rr_pick4 u_pick_rd (
    .req        (req_vec),
    .ptr        (grant_id),
    .class_mask (MASK_RD),
    .gnt_valid  (rd_valid),
    .gnt_idx    (rd_idx)
  );

  assign pick_valid = wr_valid | rd_valid;
  assign pick_idx   = wr_valid ? wr_idx : rd_idx;
`else
  rr_pick4 u_pick (
    .req        (req_vec),
    .ptr        (grant_id),
    .class_mask (MASK_ALL),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );
`endif

  // Grants are withheld whenever calibration is not complete.
  assign arb_valid = pick_valid & calib_done;

  // Length/address of the source the picker chose this cycle.
  always_comb begin
    sel_len  = '0;
    sel_addr = '0;
    case (pick_idx)
      SRC_P0_WR: begin sel_len = p0_wr_burst_len; sel_addr = p0_wr_burst_addr; end
      SRC_P0_RD: begin sel_len = p0_rd_burst_len; sel_addr = p0_rd_burst_addr; end
      SRC_P1_WR: begin sel_len = p1_wr_burst_len; sel_addr = p1_wr_burst_addr; end
      default:   begin sel_len = p1_rd_burst_len; sel_addr = p1_rd_burst_addr; end
    endcase
  end

  // Only the finish of the granted direction ends the burst.
  assign granted_finish = src_is_rd(grant_id) ? m_rd_burst_finish : m_wr_burst_finish;

  // State register.
  always_ff @(posedge mem_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; zero-length bursts bypass RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (calib_done && (|req_vec)) state_nxt = ST_ARB;
      ST_ARB: begin
        if (!arb_valid)          state_nxt = ST_IDLE;
        else if (sel_len == '0)  state_nxt = ST_DONE;
        else                     state_nxt = ST_RUN;
      end
      ST_RUN:  if (granted_finish) state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered grant, downstream request/len/addr, busy and finish pulses.
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      grant_id        <= SRC_P1_RD;
      busy            <= 1'b0;
      fin_q           <= '0;
      m_rd_burst_req  <= 1'b0;
      m_rd_burst_len  <= '0;
      m_rd_burst_addr <= '0;
      m_wr_burst_req  <= 1'b0;
      m_wr_burst_len  <= '0;
      m_wr_burst_addr <= '0;
    end else begin
      fin_q <= '0;
      case (state)
        ST_ARB: begin
          if (arb_valid) begin
            grant_id <= pick_idx;
            busy     <= 1'b1;
            if (src_is_rd(pick_idx)) begin
              m_rd_burst_len  <= sel_len;
              m_rd_burst_addr <= sel_addr;
              m_rd_burst_req  <= (sel_len != '0);
            end else begin
              m_wr_burst_len  <= sel_len;
              m_wr_burst_addr <= sel_addr;
              m_wr_burst_req  <= (sel_len != '0);
            end
          end
        end
        ST_RUN: begin
          if (granted_finish) begin
            m_rd_burst_req <= 1'b0;
            m_wr_burst_req <= 1'b0;
          end
        end
        ST_DONE: begin
          busy            <= 1'b0;
          fin_q[grant_id] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign p0_wr_burst_finish = fin_q[SRC_P0_WR];
  assign p0_rd_burst_finish = fin_q[SRC_P0_RD];
  assign p1_wr_burst_finish = fin_q[SRC_P1_WR];
  assign p1_rd_burst_finish = fin_q[SRC_P1_RD];

  // Data path: read data broadcast, strobes gated to the granted source while running.
  assign in_run                 = (state == ST_RUN);
  assign p0_rd_burst_data       = m_rd_burst_data;
  assign p1_rd_burst_data       = m_rd_burst_data;
  assign p0_rd_burst_data_valid = m_rd_burst_data_valid & in_run & (grant_id == SRC_P0_RD);
  assign p1_rd_burst_data_valid = m_rd_burst_data_valid & in_run & (grant_id == SRC_P1_RD);
  assign p0_wr_burst_data_req   = m_wr_burst_data_req & in_run & (grant_id == SRC_P0_WR);
  assign p1_wr_burst_data_req   = m_wr_burst_data_req & in_run & (grant_id == SRC_P1_WR);
  assign m_wr_burst_data        = (grant_id == SRC_P1_WR) ? p1_wr_burst_data : p0_wr_burst_data;

endmodule
